// File: rtl/alu_bitslice_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg : shared types and constants for the bit-sliced sequential ALU
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int SLICE_W = 4;

  typedef logic [3:0] sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_bitslice_seq_if.sv
// ----------------------------------------------------------------------------
// alu_bitslice_seq_if : command/result handshake bundle of the sequential ALU
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_bitslice_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) ();

  logic             in_valid_i;
  logic             in_ready_o;
  logic             mode_control_i;
  sel_t             S_selection_i;
  logic             carry_in_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] F_o;
  logic             carry_output_o;
  logic             equality_o;
  logic             zero_o;
  logic             overflow_o;

  // Slave is the ALU; master is the producer/consumer pair driving it.
  modport slave (
    input  in_valid_i, mode_control_i, S_selection_i, carry_in_i, A_i, B_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o, F_o, carry_output_o, equality_o, zero_o,
    output overflow_o
  );

  modport master (
    output in_valid_i, mode_control_i, S_selection_i, carry_in_i, A_i, B_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o, F_o, carry_output_o, equality_o, zero_o,
    input  overflow_o
  );

endinterface

`default_nettype wire

// File: rtl/alu_bitslice_seq_slice4.sv
// ----------------------------------------------------------------------------
// alu_slice4 : combinational 4-bit 74181-style function slice, active-high carry
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_slice4
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  sel_t       s,
  input  logic       m,
  input  logic       cin,
  output logic [3:0] f,
  output logic       cout,
  output logic       c3
);

  logic [3:0] w_logic;
  logic [3:0] w_x;
  logic [3:0] w_y;
  logic [4:0] w_sum;

  always_comb begin
    w_logic = '0;
    case (s)
      4'h0: w_logic = ~a;
      4'h1: w_logic = ~(a | b);
      4'h2: w_logic = ~a & b;
      4'h3: w_logic = 4'h0;
      4'h4: w_logic = ~(a & b);
      4'h5: w_logic = ~b;
      4'h6: w_logic = a ^ b;
      4'h7: w_logic = a & ~b;
      4'h8: w_logic = ~a | b;
      4'h9: w_logic = ~(a ^ b);
      4'hA: w_logic = b;
      4'hB: w_logic = a & b;
      4'hC: w_logic = 4'hF;
      4'hD: w_logic = a | ~b;
      4'hE: w_logic = a | b;
      4'hF: w_logic = a;
    endcase
  end

  // Arithmetic result is X + Y + cin; X/Y are bitwise so each nibble is exact.
  always_comb begin
    w_x = a;
    w_y = 4'h0;
    case (s)
      4'h0: begin w_x = a;      w_y = 4'h0;   end
      4'h1: begin w_x = a | b;  w_y = 4'h0;   end
      4'h2: begin w_x = a | ~b; w_y = 4'h0;   end
      4'h3: begin w_x = 4'hF;   w_y = 4'h0;   end
      4'h4: begin w_x = a;      w_y = a & ~b; end
      4'h5: begin w_x = a | b;  w_y = a & ~b; end
      4'h6: begin w_x = a;      w_y = ~b;     end
      4'h7: begin w_x = a & ~b; w_y = 4'hF;   end
      4'h8: begin w_x = a;      w_y = a & b;  end
      4'h9: begin w_x = a;      w_y = b;      end
      4'hA: begin w_x = a | ~b; w_y = a & b;  end
      4'hB: begin w_x = a & b;  w_y = 4'hF;   end
      4'hC: begin w_x = a;      w_y = a;      end
      4'hD: begin w_x = a | b;  w_y = a;      end
      4'hE: begin w_x = a | ~b; w_y = a;      end
      4'hF: begin w_x = a;      w_y = 4'hF;   end
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, cin};

  assign f    = m ? w_logic : w_sum[3:0];
  assign cout = m ? 1'b0 : w_sum[4];
  // Carry into bit 3 recovered from the sum bit and the two operand bits.
  assign c3   = m ? 1'b0 : (w_sum[3] ^ w_x[3] ^ w_y[3]);

endmodule

`default_nettype wire

// File: rtl/alu_bitslice_seq.sv
// ----------------------------------------------------------------------------
// alu_bitslice_seq : WIDTH-bit ALU iterating one 4-bit slice per clock, LSB first
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_bitslice_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  alu_bitslice_seq_if.slave  bus
);

  localparam int NUM_SLICES = WIDTH / SLICE_W;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int BASE_W     = $clog2(WIDTH);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_f;
  sel_t             r_s;
  logic             r_m;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             r_cout;
  logic             r_eq;
  logic             r_zero;
  logic             r_ovf;

  logic [BASE_W-1:0] w_base;
  logic [3:0]        w_a_nib;
  logic [3:0]        w_b_nib;
  logic [3:0]        w_slice_f;
  logic              w_slice_cout;
  logic              w_slice_c3;
  logic [WIDTH-1:0]  w_f_next;

  assign w_base  = BASE_W'(r_idx) * BASE_W'(SLICE_W);
  assign w_a_nib = r_a[w_base +: SLICE_W];
  assign w_b_nib = r_b[w_base +: SLICE_W];

  alu_slice4 u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .s    (r_s),
    .m    (r_m),
    .cin  (r_carry),
    .f    (w_slice_f),
    .cout (w_slice_cout),
    .c3   (w_slice_c3)
  );

  // Full result including the nibble being written now, so flags on the last
  // slice see the complete word.
  always_comb begin
    w_f_next = r_f;
    w_f_next[w_base +: SLICE_W] = w_slice_f;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_f     <= '0;
      r_s     <= '0;
      r_m     <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_eq    <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid_i) begin
            r_a     <= bus.A_i;
            r_b     <= bus.B_i;
            r_s     <= bus.S_selection_i;
            r_m     <= bus.mode_control_i;
            r_carry <= bus.carry_in_i & ~bus.mode_control_i;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_f     <= w_f_next;
          r_carry <= w_slice_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_slice_cout;
            r_ovf   <= w_slice_cout ^ w_slice_c3;
            r_eq    <= &w_f_next;
            r_zero  <= (w_f_next == '0);
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o     = (r_state == ST_IDLE);
  assign bus.out_valid_o    = (r_state == ST_DONE);
  assign bus.F_o            = r_f;
  assign bus.carry_output_o = r_cout;
  assign bus.equality_o     = r_eq;
  assign bus.zero_o         = r_zero;
  assign bus.overflow_o     = r_ovf;

endmodule

`default_nettype wire
